// File: rtl/id_ex_if.sv
// ID/EX stage bus bundle: the decode-side inputs plus the registered EX-side outputs.
//  master : decode/control side, drives id_valid, ctrl_in, rs/rt/rd_in, rdata_a/b,
//           imm_in, pc4_in, flush and hold_in, and observes the EX outputs.
//  slave  : the ID/EX stage, drives ex_valid, ex_ctrl, ex_rs/rt/rd, ex_a/b/imm/pc4,
//           stall_if, bubble_cnt and flush_cnt.
interface id_ex_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned CTRL_W = 10;
   localparam int unsigned REG_W  = 5;

   logic              id_valid;
   logic [CTRL_W-1:0] ctrl_in;
   logic [REG_W-1:0]  rs_in;
   logic [REG_W-1:0]  rt_in;
   logic [REG_W-1:0]  rd_in;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic [DATA_W-1:0] imm_in;
   logic [DATA_W-1:0] pc4_in;
   logic              flush;
   logic              hold_in;

   logic              ex_valid;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [REG_W-1:0]  ex_rs;
   logic [REG_W-1:0]  ex_rt;
   logic [REG_W-1:0]  ex_rd;
   logic [DATA_W-1:0] ex_a;
   logic [DATA_W-1:0] ex_b;
   logic [DATA_W-1:0] ex_imm;
   logic [DATA_W-1:0] ex_pc4;
   logic              stall_if;
   logic [CNT_W-1:0]  bubble_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_valid, ctrl_in, rs_in, rt_in, rd_in, rdata_a, rdata_b, imm_in, pc4_in,
             flush, hold_in,
      input  ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm, ex_pc4,
             stall_if, bubble_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, ctrl_in, rs_in, rt_in, rd_in, rdata_a, rdata_b, imm_in, pc4_in,
             flush, hold_in,
      output ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm, ex_pc4,
             stall_if, bubble_cnt, flush_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, downstream hold
// and saturating bubble/flush statistics counters.
//  clk, rst_n : rising-edge clock, synchronous active-low reset
//  bus        : id_ex_if slave -- decode inputs in, registered EX outputs and the
//               combinational stall_if out
module id_ex_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input logic  clk,
   input logic  rst_n,
   id_ex_if.slave bus
);
   localparam int unsigned CTRL_W = 10;
   localparam int unsigned REG_W  = 5;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              valid_q,  valid_d;
   logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
   logic [REG_W-1:0]  rs_q,     rs_d;
   logic [REG_W-1:0]  rt_q,     rt_d;
   logic [REG_W-1:0]  rd_q,     rd_d;
   logic [DATA_W-1:0] a_q,      a_d;
   logic [DATA_W-1:0] b_q,      b_d;
   logic [DATA_W-1:0] imm_q,    imm_d;
   logic [DATA_W-1:0] pc4_q,    pc4_d;
   logic [CNT_W-1:0]  bubble_q, bubble_d;
   logic [CNT_W-1:0]  flush_q,  flush_d;
   logic              lu_c;

   // Load in EX whose destination is read by the decode instruction; rt only counts
   // as a source when the decode op actually reads it (R-type, store, branch).
   always_comb begin
      lu_c = valid_q && ctrl_q[4] && (rt_q != REG_W'(0)) && bus.id_valid &&
             ((rt_q == bus.rs_in) ||
              ((rt_q == bus.rt_in) && (bus.ctrl_in[8] || bus.ctrl_in[3] || bus.ctrl_in[2])));
   end

   // A flush discards the decode slot too, so fetch must not be held.
   assign bus.stall_if = bus.flush ? 1'b0 : (lu_c || bus.hold_in);

   // Next-state: flush > hold > load-use bubble > normal load.
   always_comb begin
      valid_d  = valid_q;
      ctrl_d   = ctrl_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      rd_d     = rd_q;
      a_d      = a_q;
      b_d      = b_q;
      imm_d    = imm_q;
      pc4_d    = pc4_q;
      bubble_d = bubble_q;
      flush_d  = flush_q;
      if (bus.flush || (!bus.hold_in && lu_c)) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         rs_d    = '0;
         rt_d    = '0;
         rd_d    = '0;
         a_d     = '0;
         b_d     = '0;
         imm_d   = '0;
         pc4_d   = '0;
         if (bus.flush) begin
            flush_d = (flush_q == CNT_MAX) ? flush_q : flush_q + CNT_W'(1);
         end else begin
            bubble_d = (bubble_q == CNT_MAX) ? bubble_q : bubble_q + CNT_W'(1);
         end
      end else if (!bus.hold_in) begin
         valid_d = bus.id_valid;
         ctrl_d  = bus.id_valid ? bus.ctrl_in : '0;
         rs_d    = bus.rs_in;
         rt_d    = bus.rt_in;
         rd_d    = bus.rd_in;
         a_d     = bus.rdata_a;
         b_d     = bus.rdata_b;
         imm_d   = bus.imm_in;
         pc4_d   = bus.pc4_in;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         ctrl_q   <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         pc4_q    <= '0;
         bubble_q <= '0;
         flush_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         ctrl_q   <= ctrl_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         rd_q     <= rd_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         pc4_q    <= pc4_d;
         bubble_q <= bubble_d;
         flush_q  <= flush_d;
      end
   end

   assign bus.ex_valid   = valid_q;
   assign bus.ex_ctrl    = ctrl_q;
   assign bus.ex_rs      = rs_q;
   assign bus.ex_rt      = rt_q;
   assign bus.ex_rd      = rd_q;
   assign bus.ex_a       = a_q;
   assign bus.ex_b       = b_q;
   assign bus.ex_imm     = imm_q;
   assign bus.ex_pc4     = pc4_q;
   assign bus.bubble_cnt = bubble_q;
   assign bus.flush_cnt  = flush_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. A second instance with 4-bit counters shares the same
// stimulus so counter saturation can be reached in a short run.
module tb_id_ex_stage;
   localparam int unsigned DATA_W = 32;

   logic clk;
   logic rst_n;
   int   total;
   int   fails;

   id_ex_if #(.DATA_W(DATA_W), .CNT_W(16)) bus_a ();
   id_ex_if #(.DATA_W(DATA_W), .CNT_W(4))  bus_b ();

   id_ex_stage #(.DATA_W(DATA_W), .CNT_W(16)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   id_ex_stage #(.DATA_W(DATA_W), .CNT_W(4))  u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   assign bus_b.id_valid = bus_a.id_valid;
   assign bus_b.ctrl_in  = bus_a.ctrl_in;
   assign bus_b.rs_in    = bus_a.rs_in;
   assign bus_b.rt_in    = bus_a.rt_in;
   assign bus_b.rd_in    = bus_a.rd_in;
   assign bus_b.rdata_a  = bus_a.rdata_a;
   assign bus_b.rdata_b  = bus_a.rdata_b;
   assign bus_b.imm_in   = bus_a.imm_in;
   assign bus_b.pc4_in   = bus_a.pc4_in;
   assign bus_b.flush    = bus_a.flush;
   assign bus_b.hold_in  = bus_a.hold_in;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dec(input logic v, input logic [9:0] c, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] a,
                      input logic [31:0] b);
      bus_a.id_valid = v;
      bus_a.ctrl_in  = c;
      bus_a.rs_in    = rs;
      bus_a.rt_in    = rt;
      bus_a.rd_in    = rd;
      bus_a.rdata_a  = a;
      bus_a.rdata_b  = b;
      bus_a.imm_in   = a ^ 32'h0000_FFFF;
      bus_a.pc4_in   = b + 32'd4;
   endtask

   initial begin
      total = 0;
      fails = 0;
      rst_n = 1'b0;
      bus_a.flush   = 1'b0;
      bus_a.hold_in = 1'b0;

      // Reset held for two edges with a valid instruction presented
      dec(1'b1, 10'h262, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
      tick();
      tick();
      chk("rst_valid", 64'(bus_a.ex_valid), 64'h0);
      chk("rst_ctrl", 64'(bus_a.ex_ctrl), 64'h0);
      chk("rst_a", 64'(bus_a.ex_a), 64'h0);
      chk("rst_bcnt", 64'(bus_a.bubble_cnt), 64'h0);
      chk("rst_fcnt", 64'(bus_a.flush_cnt), 64'h0);
      rst_n = 1'b1;
      tick();
      chk("rel_ctrl", 64'(bus_a.ex_ctrl), 64'h262);
      chk("rel_valid", 64'(bus_a.ex_valid), 64'h1);
      chk("rel_a", 64'(bus_a.ex_a), 64'h11);
      chk("rel_rd", 64'(bus_a.ex_rd), 64'h3);
      chk("rel_pc4", 64'(bus_a.ex_pc4), 64'h26);

      // Load-use: lw rt=5 in EX, R-type reading rs=5 in decode
      dec(1'b1, 10'h0F0, 5'd1, 5'd5, 5'd0, 32'h100, 32'h200);
      tick();
      chk("lw_ctrl", 64'(bus_a.ex_ctrl), 64'h0F0);
      dec(1'b1, 10'h122, 5'd5, 5'd6, 5'd7, 32'hAAAA, 32'hBBBB);
      #1;
      chk("lu_stall", 64'(bus_a.stall_if), 64'h1);
      tick();
      chk("bub_valid", 64'(bus_a.ex_valid), 64'h0);
      chk("bub_ctrl", 64'(bus_a.ex_ctrl), 64'h0);
      chk("bub_a", 64'(bus_a.ex_a), 64'h0);
      chk("bub_cnt", 64'(bus_a.bubble_cnt), 64'h1);
      chk("bub_stall", 64'(bus_a.stall_if), 64'h0);
      tick();
      chk("lu_ctrl", 64'(bus_a.ex_ctrl), 64'h122);
      chk("lu_a", 64'(bus_a.ex_a), 64'hAAAA);
      chk("lu_b", 64'(bus_a.ex_b), 64'hBBBB);
      chk("lu_valid", 64'(bus_a.ex_valid), 64'h1);
      chk("lu_cnt", 64'(bus_a.bubble_cnt), 64'h1);

      // No hazard: lw to $zero, then decode reading $zero
      dec(1'b1, 10'h0F0, 5'd2, 5'd0, 5'd0, 32'h1, 32'h2);
      tick();
      dec(1'b1, 10'h122, 5'd0, 5'd9, 5'd4, 32'h3, 32'h4);
      #1;
      chk("zero_stall", 64'(bus_a.stall_if), 64'h0);
      tick();
      chk("zero_ctrl", 64'(bus_a.ex_ctrl), 64'h122);
      chk("zero_cnt", 64'(bus_a.bubble_cnt), 64'h1);

      // No hazard: lw rt=5 in EX, lw with rt=5 (rt not a source) rs=3 in decode
      dec(1'b1, 10'h0F0, 5'd1, 5'd5, 5'd0, 32'h5, 32'h6);
      tick();
      dec(1'b1, 10'h0F0, 5'd3, 5'd5, 5'd0, 32'h7, 32'h8);
      #1;
      chk("lwlw_stall", 64'(bus_a.stall_if), 64'h0);
      tick();
      chk("lwlw_rs", 64'(bus_a.ex_rs), 64'h3);
      chk("lwlw_valid", 64'(bus_a.ex_valid), 64'h1);
      chk("lwlw_cnt", 64'(bus_a.bubble_cnt), 64'h1);

      // Invalid decode slot never stalls and loads as a bubble
      dec(1'b0, 10'h122, 5'd5, 5'd5, 5'd1, 32'h9, 32'hA);
      #1;
      chk("inv_stall", 64'(bus_a.stall_if), 64'h0);
      tick();
      chk("inv_valid", 64'(bus_a.ex_valid), 64'h0);
      chk("inv_ctrl", 64'(bus_a.ex_ctrl), 64'h0);

      // Flush in the same cycle as a load-use hazard
      dec(1'b1, 10'h0F0, 5'd1, 5'd5, 5'd0, 32'h5, 32'h6);
      tick();
      dec(1'b1, 10'h122, 5'd5, 5'd6, 5'd7, 32'h1234, 32'h5678);
      bus_a.flush = 1'b1;
      #1;
      chk("fl_stall", 64'(bus_a.stall_if), 64'h0);
      tick();
      bus_a.flush = 1'b0;
      chk("fl_valid", 64'(bus_a.ex_valid), 64'h0);
      chk("fl_ctrl", 64'(bus_a.ex_ctrl), 64'h0);
      chk("fl_fcnt", 64'(bus_a.flush_cnt), 64'h1);
      chk("fl_bcnt", 64'(bus_a.bubble_cnt), 64'h1);

      // Hold: R-type in EX frozen for three cycles while decode changes
      tick();
      chk("pre_hold_a", 64'(bus_a.ex_a), 64'h1234);
      bus_a.hold_in = 1'b1;
      dec(1'b1, 10'h0F0, 5'd8, 5'd9, 5'd0, 32'h5555, 32'h6666);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_stall", 64'(bus_a.stall_if), 64'h1);
         tick();
         chk("hold_ctrl", 64'(bus_a.ex_ctrl), 64'h122);
         chk("hold_a", 64'(bus_a.ex_a), 64'h1234);
      end
      bus_a.hold_in = 1'b0;
      #1;
      chk("unhold_stall", 64'(bus_a.stall_if), 64'h0);
      tick();
      chk("unhold_ctrl", 64'(bus_a.ex_ctrl), 64'h0F0);
      chk("unhold_a", 64'(bus_a.ex_a), 64'h5555);
      chk("unhold_cnt", 64'(bus_a.bubble_cnt), 64'h1);

      // Reset asserted during a hold clears everything
      bus_a.hold_in = 1'b1;
      rst_n = 1'b0;
      tick();
      chk("rsth_valid", 64'(bus_a.ex_valid), 64'h0);
      chk("rsth_ctrl", 64'(bus_a.ex_ctrl), 64'h0);
      chk("rsth_fcnt", 64'(bus_a.flush_cnt), 64'h0);
      chk("rsth_bcnt", 64'(bus_a.bubble_cnt), 64'h0);
      rst_n = 1'b1;
      bus_a.hold_in = 1'b0;

      // Saturation: 2^4+2 load-use bubbles from a lw rs=5 rt=5 looping on itself
      dec(1'b1, 10'h0F0, 5'd5, 5'd5, 5'd0, 32'h1, 32'h2);
      tick();
      for (int k = 0; k < 18; k++) begin
         tick();
         tick();
      end
      chk("sat_bcnt_16", 64'(bus_a.bubble_cnt), 64'd18);
      chk("sat_bcnt_4", 64'(bus_b.bubble_cnt), 64'hF);
      bus_a.flush = 1'b1;
      for (int k = 0; k < 18; k++) tick();
      bus_a.flush = 1'b0;
      chk("sat_fcnt_16", 64'(bus_a.flush_cnt), 64'd18);
      chk("sat_fcnt_4", 64'(bus_b.flush_cnt), 64'hF);
      chk("sat_bcnt_4_keep", 64'(bus_b.bubble_cnt), 64'hF);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
